// File: rtl/image_loader_20x20.sv
// Frame-buffer loader: packs a raster stream of pixels into a flat
// image vector that feeds the 400-to-1 pixel multiplexer.
module image_loader_20x20 #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20,
    parameter int PIX_W  = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [PIX_W-1:0]                pix_in,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [WIDTH*HEIGHT*PIX_W-1:0]   image,
    output logic                            image_done,
    output logic                            done_pulse,
    output logic                            busy,
    output logic [8:0]                      pix_count,
    output logic [4:0]                      row,
    output logic [4:0]                      col
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int IMG_W = NPIX * PIX_W;

    localparam logic [8:0] CNT_LAST = 9'(NPIX - 1);
    localparam logic [4:0] COL_LAST = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [4:0]         row_q, row_d;
    logic [4:0]         col_q, col_d;
    logic [IMG_W-1:0]   image_q, image_d;
    logic               pulse_q, pulse_d;
    logic               xfer;
    logic [11:0]        idx;

    // State, counters and frame storage; rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            image_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            image_q <= image_d;
            pulse_q <= pulse_d;
        end
    end

    // Next-state: start always (re)opens a frame; a restart that
    // coincides with a transfer lands that pixel at index 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        image_d = image_q;
        pulse_d = 1'b0;
        xfer    = pix_valid && (state_q == LOAD);
        idx     = 12'(cnt_q) * 12'(PIX_W);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD: begin
                if (start) begin
                    cnt_d = '0;
                    row_d = '0;
                    col_d = '0;
                    if (xfer) begin
                        image_d[PIX_W-1:0] = pix_in;
                        cnt_d              = 9'd1;
                        col_d              = 5'd1;
                    end
                end else if (xfer) begin
                    image_d[idx +: PIX_W] = pix_in;
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        pulse_d = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 5'd1;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status decode purely from registered state
    always_comb begin
        pix_ready  = (state_q == LOAD);
        busy       = (state_q == LOAD);
        image_done = (state_q == DONE);
        done_pulse = pulse_q;
        pix_count  = cnt_q;
        row        = row_q;
        col        = col_q;
        image      = image_q;
    end

endmodule

// File: tb/tb_image_loader_20x20.sv
// Self-checking bench for image_loader_20x20 against a frame-level
// model (pixel array plus accepted-pixel count).
module tb_image_loader_20x20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [8:0]    pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [3599:0] image;
    logic          image_done;
    logic          done_pulse;
    logic          busy;
    logic [8:0]    pix_count;
    logic [4:0]    row;
    logic [4:0]    col;

    int tests = 0;
    int fails = 0;

    logic [8:0] m_img [400];
    bit         m_load;
    bit         m_done;
    bit         m_pulse;
    int         m_cnt;

    wire [22:0] dut_st = {pix_ready, busy, image_done, done_pulse,
                          pix_count, row, col};

    image_loader_20x20 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .image      (image),
        .image_done (image_done),
        .done_pulse (done_pulse),
        .busy       (busy),
        .pix_count  (pix_count),
        .row        (row),
        .col        (col)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] model_st();
        int r;
        int c;
        r = (m_cnt >= 400) ? 0 : m_cnt / 20;
        c = m_cnt % 20;
        return {m_load, m_load, m_done, m_pulse,
                9'(m_cnt), 5'(r), 5'(c)};
    endfunction

    function automatic logic [3599:0] model_image();
        logic [3599:0] v;
        v = '0;
        for (int k = 0; k < 400; k++) v[9*k +: 9] = m_img[k];
        return v;
    endfunction

    function automatic int first_diff();
        for (int k = 0; k < 400; k++)
            if (image[9*k +: 9] !== m_img[k]) return k;
        return 0;
    endfunction

    // Apply the frame-level rules for the current inputs, then clock
    task automatic tick();
        bit acc;
        acc = m_load && pix_valid;
        if (rst) begin
            m_load = 0; m_done = 0; m_pulse = 0; m_cnt = 0;
            for (int k = 0; k < 400; k++) m_img[k] = '0;
        end else begin
            m_pulse = 0;
            if (start && m_load) begin
                m_cnt = 0;
                if (acc) begin
                    m_img[0] = pix_in;
                    m_cnt = 1;
                end
            end else if (start) begin
                m_load = 1; m_done = 0; m_cnt = 0;
            end else if (acc) begin
                m_img[m_cnt] = pix_in;
                m_cnt++;
                if (m_cnt == 400) begin
                    m_load = 0; m_done = 1; m_pulse = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; pix_valid = 1; pix_in = 9'h123; start = 1;
        tick();
        start = 0;
        tick();
        rst = 0; pix_valid = 0;
        tests++;
        if (dut_st !== 23'd0) begin
            fails++;
            $display("FAIL reset_status: got %h want 0", dut_st);
        end
        tests++;
        if (image !== '0) begin
            fails++;
            $display("FAIL reset_image: pix %0d got %h want 0",
                     first_diff(), image[9*first_diff() +: 9]);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        start = 1; tick(); start = 0;
        tests++;
        if (dut_st !== model_st()) begin
            fails++;
            $display("FAIL b2b_start: got %h want %h", dut_st, model_st());
        end
        for (int k = 0; k < 400; k++) begin
            pix_in = 9'(k); pix_valid = 1;
            tick();
            if (done_pulse) pulses++;
        end
        pix_valid = 0;
        tests++;
        if (image[8:0] !== 9'd0) begin
            fails++;
            $display("FAIL b2b_pix0: got %0d want 0", image[8:0]);
        end
        tests++;
        if (image[3599:3591] !== 9'd399) begin
            fails++;
            $display("FAIL b2b_pix399: got %0d want 399", image[3599:3591]);
        end
        tests++;
        if (image[9*137 +: 9] !== 9'd137) begin
            fails++;
            $display("FAIL b2b_pix137: got %0d want 137", image[9*137 +: 9]);
        end
        tests++;
        if (dut_st !== model_st()) begin
            fails++;
            $display("FAIL b2b_done: got %h want %h", dut_st, model_st());
        end
        tick();
        if (done_pulse) pulses++;
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL b2b_pulse_count: got %0d want 1", pulses);
        end
        tests++;
        if (pix_ready !== 1'b0 || image_done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_after: got rdy %b done %b want 0 1",
                     pix_ready, image_done);
        end
    endtask

    task automatic test_bubbles();
        int k;
        int bad;
        k = 0; bad = 0;
        start = 1; tick(); start = 0;
        for (int cyc = 0; cyc < 4000 && k < 400; cyc++) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_in = 9'(k);
            tick();
            if (pix_valid) k++;
            tests++;
            if (dut_st !== model_st()) begin
                fails++; bad++;
                if (bad < 5)
                    $display("FAIL bub_status: k %0d got %h want %h",
                             k, dut_st, model_st());
            end
            if (pix_valid && k == 20) begin
                tests++;
                if (row !== 5'd1 || col !== 5'd0) begin
                    fails++;
                    $display("FAIL bub_rc20: got %0d/%0d want 1/0", row, col);
                end
            end
            if (pix_valid && k == 399) begin
                tests++;
                if (row !== 5'd19 || col !== 5'd19) begin
                    fails++;
                    $display("FAIL bub_rc399: got %0d/%0d want 19/19", row, col);
                end
            end
        end
        pix_valid = 0;
        tests++;
        if (k != 400) begin
            fails++;
            $display("FAIL bub_timeout: got %0d pixels want 400", k);
        end
        tests++;
        if (image !== model_image()) begin
            fails++;
            $display("FAIL bub_image: pix %0d got %h want %h",
                     first_diff(), image[9*first_diff() +: 9],
                     m_img[first_diff()]);
        end
    endtask

    task automatic test_restart();
        int bad;
        bad = 0;
        start = 1; tick(); start = 0;
        for (int i = 0; i < 150; i++) begin
            pix_in = 9'h1FF; pix_valid = 1; tick();
        end
        start = 1; pix_in = 9'h055; pix_valid = 1;
        tick();
        start = 0; pix_valid = 0;
        tests++;
        if (image[8:0] !== 9'h055) begin
            fails++;
            $display("FAIL rst_pix0: got %h want 055", image[8:0]);
        end
        tests++;
        if (pix_count !== 9'd1 || col !== 5'd1 || row !== 5'd0) begin
            fails++;
            $display("FAIL rst_cnt: got %0d r%0d c%0d want 1 r0 c1",
                     pix_count, row, col);
        end
        for (int i = 1; i < 150; i++)
            if (image[9*i +: 9] !== 9'h1FF) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL rst_keep: got %0d changed want 0", bad);
        end
        tests++;
        if (image[9*150 +: 9] !== 9'd150) begin
            fails++;
            $display("FAIL rst_old: got %0d want 150", image[9*150 +: 9]);
        end
        for (int i = 1; i < 400; i++) begin
            pix_in = 9'($urandom); pix_valid = 1; tick();
        end
        pix_valid = 0;
        tests++;
        if (image !== model_image() || dut_st !== model_st()) begin
            fails++;
            $display("FAIL rst_frame: pix %0d got %h want %h st %h/%h",
                     first_diff(), image[9*first_diff() +: 9],
                     m_img[first_diff()], dut_st, model_st());
        end
    endtask

    task automatic test_done_ignore();
        logic [3599:0] snap;
        snap = model_image();
        pix_valid = 1; pix_in = 9'h0AA;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (image !== snap || pix_ready !== 1'b0 || pix_count !== 9'd400) begin
                fails++;
                $display("FAIL done_ign: cyc %0d rdy %b cnt %0d pix %0d %h",
                         i, pix_ready, pix_count, first_diff(),
                         image[9*first_diff() +: 9]);
            end
        end
        pix_valid = 0;
    endtask

    task automatic test_reset_mid();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 200; i++) begin
            pix_in = 9'($urandom); pix_valid = 1; tick();
        end
        tests++;
        if (pix_count !== 9'd200) begin
            fails++;
            $display("FAIL mid_cnt: got %0d want 200", pix_count);
        end
        rst = 1; tick(); rst = 0; pix_valid = 0;
        tests++;
        if (dut_st !== 23'd0 || image !== '0) begin
            fails++;
            $display("FAIL mid_reset: got st %h pix %0d %h want 0",
                     dut_st, first_diff(), image[9*first_diff() +: 9]);
        end
    endtask

    task automatic test_second_frame();
        int bad;
        bad = 0;
        start = 1; tick(); start = 0;
        for (int k = 0; k < 400; k++) begin
            pix_in = 9'(k); pix_valid = 1; tick();
        end
        pix_valid = 0;
        start = 1; tick(); start = 0;
        tests++;
        if (dut_st !== model_st()) begin
            fails++;
            $display("FAIL sf_restart: got %h want %h", dut_st, model_st());
        end
        for (int k = 0; k < 400; k++) begin
            pix_in = 9'(399 - k); pix_valid = 1; tick();
            if (k < 399 && image_done !== 1'b0) bad++;
        end
        pix_valid = 0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL sf_done_low: got %0d high cycles want 0", bad);
        end
        tests++;
        if (image_done !== 1'b1) begin
            fails++;
            $display("FAIL sf_done_high: got %b want 1", image_done);
        end
        tests++;
        if (image[8:0] !== 9'd399 || image[3599:3591] !== 9'd0) begin
            fails++;
            $display("FAIL sf_ends: got %0d %0d want 399 0",
                     image[8:0], image[3599:3591]);
        end
        tests++;
        if (image !== model_image()) begin
            fails++;
            $display("FAIL sf_image: pix %0d got %h want %h",
                     first_diff(), image[9*first_diff() +: 9],
                     m_img[first_diff()]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_load = 0; m_done = 0; m_pulse = 0; m_cnt = 0;
        for (int k = 0; k < 400; k++) m_img[k] = '0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_restart();
        test_done_ignore();
        test_reset_mid();
        test_second_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
